region_dispatcher: RTL
======================

Name: region_dispatcher

Overview:
- Sits directly downstream of the load balancer.
- Takes each metadata beat together with the balancer's region choice (lb_ctrl) and forwards it to that region's metadata channel.
- If the request has a body, streams the body beats to the same region.
- Keeps a per-region outstanding-request counter and last-dispatched operator ID. These are exported as the region status vector that the load balancer consumes.

Parameters:
HTTP_META_WIDTH, 98, metadata word width; oid at [15:0], has_body at [OPERATOR_ID_WIDTH]
HTTP_DATA_WIDTH, 512, body beat width
OPERATOR_ID_WIDTH, 16, operator ID width
N_REGIONS, 4, number of regions; must be a power of two, elaboration-time assertion
QDEPTH, 16, per-region outstanding capacity; LOAD_BITS = $clog2(QDEPTH) (localparam)

Ports:
aclk  in  1  clock
aresetn  in  1  reset; synchronous, active-low
meta_in_tvalid  in  1  metadata valid
meta_in_tready  out  1  metadata accept
meta_in_tdata  in  HTTP_META_WIDTH  metadata
lb_ctrl  in  $clog2(N_REGIONS)  target region; qualified by meta_in_tvalid
bdy_in_tvalid  in  1  body valid
bdy_in_tready  out  1  body accept
bdy_in_tdata  in  HTTP_DATA_WIDTH  body data
bdy_in_tlast  in  1  last body beat
reg_meta_tvalid  out  N_REGIONS  per-region metadata valid (one-hot or zero)
reg_meta_tready  in  N_REGIONS  per-region metadata ready
reg_meta_tdata  out  HTTP_META_WIDTH  shared metadata bus
reg_bdy_tvalid  out  N_REGIONS  per-region body valid (one-hot or zero)
reg_bdy_tready  in  N_REGIONS  per-region body ready
reg_bdy_tdata  out  HTTP_DATA_WIDTH  shared body bus
reg_bdy_tlast  out  1  shared tlast
done_valid  in  N_REGIONS  one-cycle completion pulse per region
region_stats_out  out  N_REGIONS*(OPERATOR_ID_WIDTH+LOAD_BITS)  region r at [r*W +: W], W = OPERATOR_ID_WIDTH+LOAD_BITS, packed {oid, load} (load in LSBs)
region_full  out  N_REGIONS  load[r] == 2**LOAD_BITS-1
err_underflow  out  1  sticky; set when done_valid hits a region whose load is 0

Behaviour:
- Reset (aresetn=0 at posedge):
  - State is IDLE.
  - All load counters, oid registers, the sel register, the latched metadata and err_underflow are cleared.
  - Outputs are 0 from the following cycle.
  - Reset mid-request abandons that request. Body beats not yet forwarded are not drained; the upstream is reset together with this block.
- FSM, states IDLE, META, BODY:
  - IDLE:
    - meta_in_tready = meta_in_tvalid && !region_full[lb_ctrl] (combinational).
    - On handshake: latch tdata into meta_q, sel <= lb_ctrl, go to META.
    - If the target region is full, stall. lb_ctrl is re-evaluated every cycle.
  - META:
    - reg_meta_tvalid[sel] = 1, reg_meta_tdata = meta_q.
    - Hold both until reg_meta_tready[sel].
    - On handshake: load[sel]++ and oid[sel] <= meta_q[OPERATOR_ID_WIDTH-1:0].
    - Next state is BODY if meta_q has_body = 1, otherwise IDLE.
  - BODY:
    - Combinational pass-through: reg_bdy_tvalid[sel] = bdy_in_tvalid, bdy_in_tready = reg_bdy_tready[sel], data and tlast forwarded.
    - A handshake with bdy_in_tlast = 1 returns to IDLE.
  - bdy_in_tready = 0 and all reg_bdy_tvalid = 0 outside BODY.
- Latency:
  - Metadata accepted at cycle t appears on reg_meta_tvalid at t+1.
  - Body adds zero cycles.
  - Body-less requests: at most one request per 2 cycles.
- Counters (per region, independent):
  - Increment on dispatch handshake; decrement on done_valid[r].
  - Both in the same cycle: unchanged.
  - Decrement at 0: counter stays 0, err_underflow set.
  - Increment never occurs at max because full regions are not accepted.
- region_stats_out and region_full are driven directly from registers. A dispatch at cycle t is visible at t+1.
- meta_in_tdata is sampled only on handshake. lb_ctrl is sampled only with meta_in_tvalid.

Test Plan:
1. Reset, then meta {oid=0x0007, has_body=0}, lb_ctrl=2, region ready -> reg_meta_tvalid=4'b0100 one cycle after accept; afterwards region 2 stats = {0x0007, 1}, others 0.
2. Meta has_body=1, lb_ctrl=1, 3 body beats with tlast on the 3rd; reg_bdy_tready[1] toggles 1,0,1,1 -> exactly 3 beats on region 1, data in order, no beat on other regions; FSM back in IDLE.
3. Dispatch 15 requests to region 0 -> region_full[0]=1. 16th request targeting 0 stalls with meta_in_tready=0. One done_valid[0] pulse -> load 14, request accepted next cycle, load 15.
4. Same cycle dispatch handshake and done_valid on region 3 at load 5 -> load stays 5. done_valid[1] at load 0 -> load stays 0, err_underflow=1 until reset.
5. reg_meta_tready[sel]=0 for 10 cycles -> reg_meta_tvalid and tdata stable, meta_in_tready=0, no counter change.
6. aresetn asserted during BODY after 1 of 4 beats -> next cycle all valids/readies 0, stats 0, state IDLE, new request dispatches normally.

Source files
------------

// File: rtl/region_dispatcher.sv
// region_dispatcher
//   Forwards each metadata beat to the region picked by the load balancer
//   (lb_ctrl) and, when the request carries a body, streams the body beats to
//   that same region. Per-region outstanding-request counters and the last
//   dispatched operator ID are exported to the balancer as region status.
//
// Ports
//   aclk, aresetn            clock, synchronous active-low reset
//   meta_in_*, lb_ctrl       upstream metadata stream plus target region
//   bdy_in_*                 upstream body stream
//   reg_meta_*               per-region metadata valid/ready, shared data bus
//   reg_bdy_*                per-region body valid/ready, shared data/tlast
//   done_valid               per-region completion pulse (decrements load)
//   region_stats_out         {oid, load} per region, region r at [r*W +: W]
//   region_full              load at its maximum; new requests to it stall
//   err_underflow            sticky: completion seen on a region with load 0
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a metadata beat whose target region is not full
// META  | presenting latched metadata to region sel until it is accepted
// BODY  | passing body beats through to region sel until the tlast beat
module region_dispatcher #(
    parameter int HTTP_META_WIDTH   = 98,
    parameter int HTTP_DATA_WIDTH   = 512,
    parameter int OPERATOR_ID_WIDTH = 16,
    parameter int N_REGIONS         = 4,
    parameter int QDEPTH            = 16
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic                                  meta_in_tvalid,
    output logic                                  meta_in_tready,
    input  logic [HTTP_META_WIDTH-1:0]            meta_in_tdata,
    input  logic [$clog2(N_REGIONS)-1:0]          lb_ctrl,
    input  logic                                  bdy_in_tvalid,
    output logic                                  bdy_in_tready,
    input  logic [HTTP_DATA_WIDTH-1:0]            bdy_in_tdata,
    input  logic                                  bdy_in_tlast,
    output logic [N_REGIONS-1:0]                  reg_meta_tvalid,
    input  logic [N_REGIONS-1:0]                  reg_meta_tready,
    output logic [HTTP_META_WIDTH-1:0]            reg_meta_tdata,
    output logic [N_REGIONS-1:0]                  reg_bdy_tvalid,
    input  logic [N_REGIONS-1:0]                  reg_bdy_tready,
    output logic [HTTP_DATA_WIDTH-1:0]            reg_bdy_tdata,
    output logic                                  reg_bdy_tlast,
    input  logic [N_REGIONS-1:0]                  done_valid,
    output logic [N_REGIONS*(OPERATOR_ID_WIDTH+$clog2(QDEPTH))-1:0] region_stats_out,
    output logic [N_REGIONS-1:0]                  region_full,
    output logic                                  err_underflow
);

    localparam int SEL_BITS  = $clog2(N_REGIONS);
    localparam int LOAD_BITS = $clog2(QDEPTH);
    localparam int STAT_W    = OPERATOR_ID_WIDTH + LOAD_BITS;
    localparam logic [LOAD_BITS-1:0] LOAD_MAX = '1;

    generate
        if (N_REGIONS < 2 || (N_REGIONS & (N_REGIONS - 1)) != 0) begin : g_bad_regions
            $error("region_dispatcher: N_REGIONS must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_META = 2'd1,
        S_BODY = 2'd2
    } state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic [SEL_BITS-1:0]           sel;
    logic [HTTP_META_WIDTH-1:0]    meta_q;
    logic [LOAD_BITS-1:0]          load [N_REGIONS];
    logic [OPERATOR_ID_WIDTH-1:0]  oid  [N_REGIONS];

    logic                          meta_in_hs;
    logic                          meta_out_hs;
    logic                          body_last_hs;
    logic [N_REGIONS-1:0]          disp_inc;
    logic [N_REGIONS-1:0]          uflow;

    assign meta_in_hs   = meta_in_tvalid && meta_in_tready;
    assign meta_out_hs  = (state == S_META) && reg_meta_tready[sel];
    assign body_last_hs = (state == S_BODY) && bdy_in_tvalid && reg_bdy_tready[sel]
                          && bdy_in_tlast;

    // ---------------- state register ----------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (meta_in_hs) state_nxt = S_META;
            S_META: if (meta_out_hs) begin
                state_nxt = meta_q[OPERATOR_ID_WIDTH] ? S_BODY : S_IDLE;
            end
            S_BODY: if (body_last_hs) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        meta_in_tready  = 1'b0;
        reg_meta_tvalid = '0;
        reg_bdy_tvalid  = '0;
        bdy_in_tready   = 1'b0;
        reg_bdy_tdata   = '0;
        reg_bdy_tlast   = 1'b0;
        case (state)
            // A full target stalls; lb_ctrl may change while we wait.
            S_IDLE: meta_in_tready = meta_in_tvalid && !region_full[lb_ctrl];
            S_META: reg_meta_tvalid[sel] = 1'b1;
            S_BODY: begin
                reg_bdy_tvalid[sel] = bdy_in_tvalid;
                bdy_in_tready       = reg_bdy_tready[sel];
                reg_bdy_tdata       = bdy_in_tdata;
                reg_bdy_tlast       = bdy_in_tlast;
            end
            default: ;
        endcase
    end

    assign reg_meta_tdata = meta_q;

    // ---------------- request latch ----------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sel    <= '0;
            meta_q <= '0;
        end else if (meta_in_hs) begin
            sel    <= lb_ctrl;
            meta_q <= meta_in_tdata;
        end
    end

    // ---------------- per-region load / oid ----------------
    always_comb begin
        disp_inc = '0;
        if (meta_out_hs) disp_inc[sel] = 1'b1;
    end

    // A dispatch in the same cycle as a completion cancels it, so it is not an
    // underflow even when the load is 0.
    always_comb begin
        uflow = '0;
        for (int r = 0; r < N_REGIONS; r++) begin
            uflow[r] = done_valid[r] && !disp_inc[r] && (load[r] == '0);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int r = 0; r < N_REGIONS; r++) begin
                load[r] <= '0;
                oid[r]  <= '0;
            end
            err_underflow <= 1'b0;
        end else begin
            for (int r = 0; r < N_REGIONS; r++) begin
                if (disp_inc[r] && !done_valid[r]) begin
                    load[r] <= load[r] + 1'b1;
                end else if (!disp_inc[r] && done_valid[r] && (load[r] != '0)) begin
                    load[r] <= load[r] - 1'b1;
                end
                if (disp_inc[r]) begin
                    oid[r] <= meta_q[OPERATOR_ID_WIDTH-1:0];
                end
            end
            if (|uflow) err_underflow <= 1'b1;
        end
    end

    // ---------------- status export ----------------
    generate
        for (genvar g = 0; g < N_REGIONS; g++) begin : g_stats
            assign region_stats_out[g*STAT_W +: STAT_W] = {oid[g], load[g]};
            assign region_full[g] = (load[g] == LOAD_MAX);
        end
    endgenerate

endmodule
